// File: rtl/id_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : RV32I opcodes, ALU-op codes and the ID-stage control bundle.
//  Revision    : 1.0
// ============================================================================
package pipeline_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic       AluSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] Aluop;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_R:    c = '{AluSrc: 1'b0, MemtoReg: 1'b0, RegWrite: 1'b1, MemRead: 1'b0, MemWrite: 1'b0, Aluop: ALUOP_RTYPE};
            OP_I:    c = '{AluSrc: 1'b1, MemtoReg: 1'b0, RegWrite: 1'b1, MemRead: 1'b0, MemWrite: 1'b0, Aluop: ALUOP_ITYPE};
            OP_LW:   c = '{AluSrc: 1'b1, MemtoReg: 1'b1, RegWrite: 1'b1, MemRead: 1'b1, MemWrite: 1'b0, Aluop: ALUOP_ADD};
            OP_SW:   c = '{AluSrc: 1'b1, MemtoReg: 1'b0, RegWrite: 1'b0, MemRead: 1'b0, MemWrite: 1'b1, Aluop: ALUOP_ADD};
            OP_BEQ:  c = '{AluSrc: 1'b0, MemtoReg: 1'b0, RegWrite: 1'b0, MemRead: 1'b0, MemWrite: 1'b0, Aluop: ALUOP_SUB};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_stage_if
//  Description : IF/ID, write-back and ID/EX-feedback bus of the decode stage.
//  Revision    : 1.0
// ============================================================================
interface id_decode_stage_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instr_in;
    logic            flush_in;
    logic            wb_RegWrite_in;
    logic [4:0]      wb_rd_in;
    logic [XLEN-1:0] wb_data_in;
    logic            ex_MemRead_in;
    logic [4:0]      ex_rd_in;

    logic            AluSrc_out;
    logic            MemtoReg_out;
    logic            RegWrite_out;
    logic            MemRead_out;
    logic            MemWrite_out;
    logic [1:0]      Aluop_out;
    logic [XLEN-1:0] rs1Data_out;
    logic [XLEN-1:0] rs2Data_out;
    logic [4:0]      rs_out;
    logic [4:0]      rt_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] immediate_out;
    logic            stall_out;

    modport master (
        output instr_in, flush_in, wb_RegWrite_in, wb_rd_in, wb_data_in,
               ex_MemRead_in, ex_rd_in,
        input  AluSrc_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out,
               Aluop_out, rs1Data_out, rs2Data_out, rs_out, rt_out, rd_out,
               immediate_out, stall_out
    );

    modport slave (
        input  instr_in, flush_in, wb_RegWrite_in, wb_rd_in, wb_data_in,
               ex_MemRead_in, ex_rd_in,
        output AluSrc_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out,
               Aluop_out, rs1Data_out, rs2Data_out, rs_out, rt_out, rd_out,
               immediate_out, stall_out
    );
endinterface
`default_nettype wire

// File: rtl/id_decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : NREGS x XLEN register file, 1W/2R, write-through, x0 = 0.
//  Revision    : 1.0
// ============================================================================
module reg_file
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we,
    input  wire logic [REG_AW-1:0] waddr,
    input  wire logic [XLEN-1:0]   wdata,
    input  wire logic [REG_AW-1:0] raddr1,
    input  wire logic [REG_AW-1:0] raddr2,
    output logic      [XLEN-1:0]   rdata1,
    output logic      [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = we && (waddr != '0);

    // Reset takes priority, so a write landing in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = r_regs[raddr1];
        rdata2 = r_regs[raddr2];
        if (w_wr_en && (waddr == raddr1)) rdata1 = wdata;
        if (w_wr_en && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule
`default_nettype wire

// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode_stage
//  Description : RV32I decode: register file, control decode, immediates and
//                load-use hazard detection feeding ID/EX.
//  Revision    : 1.0
// ============================================================================
module id_decode_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    id_decode_stage_if.slave bus
);

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    ctrl_t           w_ctrl;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_hazard;
    logic            w_bubble;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic [XLEN-1:0] w_imm;

    assign w_opcode = bus.instr_in[6:0];
    assign w_rs     = bus.instr_in[19:15];
    assign w_rt     = bus.instr_in[24:20];
    assign w_rd     = bus.instr_in[11:7];
    assign w_ctrl   = decode_ctrl(w_opcode);

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_RegWrite_in),
        .waddr  (bus.wb_rd_in),
        .wdata  (bus.wb_data_in),
        .raddr1 (w_rs),
        .raddr2 (w_rt),
        .rdata1 (w_rdata1),
        .rdata2 (w_rdata2)
    );

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_imm     = '0;
        case (w_opcode)
            OP_R: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_I, OP_LW: begin
                w_use_rs1 = 1'b1;
                w_imm     = {{(XLEN-12){bus.instr_in[31]}}, bus.instr_in[31:20]};
            end
            OP_SW: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = {{(XLEN-12){bus.instr_in[31]}}, bus.instr_in[31:25], bus.instr_in[11:7]};
            end
            OP_BEQ: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = {{(XLEN-13){bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[7],
                             bus.instr_in[30:25], bus.instr_in[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_hazard = bus.ex_MemRead_in && (bus.ex_rd_in != '0) &&
                      ((w_use_rs1 && (bus.ex_rd_in == w_rs)) ||
                       (w_use_rs2 && (bus.ex_rd_in == w_rt)));

    // A flush already kills this instruction, so freezing PC would be wrong.
    assign w_bubble = w_hazard || bus.flush_in || !rst;

    always_comb begin
        bus.AluSrc_out    = w_bubble ? 1'b0 : w_ctrl.AluSrc;
        bus.MemtoReg_out  = w_bubble ? 1'b0 : w_ctrl.MemtoReg;
        bus.RegWrite_out  = w_bubble ? 1'b0 : w_ctrl.RegWrite;
        bus.MemRead_out   = w_bubble ? 1'b0 : w_ctrl.MemRead;
        bus.MemWrite_out  = w_bubble ? 1'b0 : w_ctrl.MemWrite;
        bus.Aluop_out     = w_bubble ? 2'b00 : w_ctrl.Aluop;
        bus.stall_out     = w_hazard && !bus.flush_in && rst;
        bus.rs1Data_out   = rst ? w_rdata1 : '0;
        bus.rs2Data_out   = rst ? w_rdata2 : '0;
        bus.rs_out        = w_rs;
        bus.rt_out        = w_rt;
        bus.rd_out        = w_rd;
        bus.immediate_out = w_imm;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_decode_stage
//  Description : Scoreboard bench for id_decode_stage with a reference model.
//  Revision    : 1.0
// ============================================================================
module tb_id_decode_stage;

    logic clk;
    logic rst;

    id_decode_stage_if #(.XLEN(32)) bus ();

    id_decode_stage #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [14:0] idx;
        logic        stall;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Architectural state as seen by software: reset clears, x0 never changes.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
        end else if (bus.wb_RegWrite_in && bus.wb_rd_in != 5'd0) begin
            m_regs[bus.wb_rd_in] <= bus.wb_data_in;
        end
    end

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (bus.wb_RegWrite_in && bus.wb_rd_in == idx) return bus.wb_data_in;
        return m_regs[idx];
    endfunction

    function automatic exp_t ref_model(input logic [31:0] ins);
        exp_t e;
        int   v;
        logic u1, u2;
        logic [4:0] rs, rt;
        rs = ins[19:15];
        rt = ins[24:20];
        v  = 0;
        u1 = 1'b0;
        u2 = 1'b0;
        e.ctrl = 7'b0;
        case (ins[6:0])
            7'h33: begin e.ctrl = 7'b0010010; u1 = 1; u2 = 1; end
            7'h13: begin e.ctrl = 7'b1010011; u1 = 1; v = int'(ins[31:20]); end
            7'h03: begin e.ctrl = 7'b1111000; u1 = 1; v = int'(ins[31:20]); end
            7'h23: begin e.ctrl = 7'b1000100; u1 = 1; u2 = 1;
                         v = int'(ins[31:25]) * 32 + int'(ins[11:7]); end
            7'h63: begin e.ctrl = 7'b0000001; u1 = 1; u2 = 1;
                         v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                             int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
            default: ;
        endcase
        if (ins[6:0] == 7'h63) begin
            if (v >= 4096) v = v - 8192;
        end else if (v >= 2048) begin
            v = v - 4096;
        end
        e.imm   = 32'(v);
        e.idx   = {ins[19:15], ins[24:20], ins[11:7]};
        e.stall = bus.ex_MemRead_in && bus.ex_rd_in != 5'd0 &&
                  ((u1 && bus.ex_rd_in == rs) || (u2 && bus.ex_rd_in == rt));
        e.d1 = ref_read(rs);
        e.d2 = ref_read(rt);
        if (e.stall || bus.flush_in) e.ctrl = 7'b0;
        if (bus.flush_in) e.stall = 1'b0;
        if (!rst) begin
            e.ctrl  = 7'b0;
            e.stall = 1'b0;
            e.d1    = 32'h0;
            e.d2    = 32'h0;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic exmr, input logic [4:0] exrd);
        @(posedge clk);
        #1;
        rst                = r;
        bus.instr_in       = ins;
        bus.flush_in       = fl;
        bus.wb_RegWrite_in = we;
        bus.wb_rd_in       = wrd;
        bus.wb_data_in     = wd;
        bus.ex_MemRead_in  = exmr;
        bus.ex_rd_in       = exrd;
        #0;
        sb.push_back(ref_model(ins));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctrl", 32'({bus.AluSrc_out, bus.MemtoReg_out, bus.RegWrite_out,
                               bus.MemRead_out, bus.MemWrite_out, bus.Aluop_out}), 32'(e.ctrl));
            check("rs1Data", bus.rs1Data_out, e.d1);
            check("rs2Data", bus.rs2Data_out, e.d2);
            check("immediate", bus.immediate_out, e.imm);
            check("indices", 32'({bus.rs_out, bus.rt_out, bus.rd_out}), 32'(e.idx));
            check("stall", 32'(bus.stall_out), 32'(e.stall));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic [6:0]  ops [6];
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h7F;

        rst = 1'b0;
        bus.instr_in = 32'h0; bus.flush_in = 1'b0; bus.wb_RegWrite_in = 1'b0;
        bus.wb_rd_in = 5'd0; bus.wb_data_in = 32'h0; bus.ex_MemRead_in = 1'b0;
        bus.ex_rd_in = 5'd0;

        // reset, write x5, reset two cycles, x5 must read back 0
        step(0, 32'h00528233, 0, 0, 0, 0, 0, 0);
        step(1, 32'h00528233, 0, 1, 5, 32'h5555_AAAA, 0, 0);
        step(1, 32'h00528233, 0, 0, 0, 0, 0, 0);
        step(0, 32'h00528233, 0, 1, 5, 32'h1111_2222, 0, 0);
        step(0, 32'h00528233, 0, 0, 0, 0, 0, 0);
        step(1, 32'h00528233, 0, 0, 0, 0, 0, 0);
        // write-through of x3 then registered read
        step(1, 32'h003180B3, 0, 1, 3, 32'hDEADBEEF, 0, 0);
        step(1, 32'h003180B3, 0, 0, 0, 0, 0, 0);
        // x0 is immutable
        step(1, 32'h000000B3, 0, 1, 0, 32'h0000_1234, 0, 0);
        step(1, 32'h000000B3, 0, 0, 0, 0, 0, 0);
        // load and branch immediates
        step(1, 32'hFFC0A103, 0, 0, 0, 0, 0, 0);
        step(1, 32'hFE208CE3, 0, 0, 0, 0, 0, 0);
        // load-use hazards
        step(1, 32'h00110233, 0, 0, 0, 0, 1, 2);
        step(1, 32'h00110233, 0, 0, 0, 0, 1, 0);
        step(1, 32'h00108213, 0, 0, 0, 0, 1, 1);
        step(1, 32'h00108213, 0, 0, 0, 0, 1, 2);
        // flush overrides stall, write in a stalled cycle still lands
        step(1, 32'h00110233, 1, 0, 0, 0, 1, 2);
        step(1, 32'h00110233, 0, 1, 2, 32'hCAFE_F00D, 1, 2);
        step(1, 32'h00110233, 0, 0, 0, 0, 0, 0);
        step(1, 32'h0000007F, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 500; n++) begin
            ins = $urandom;
            ins[6:0]   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 39) != 0), ins, ($urandom_range(0, 7) == 0),
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)));
        end

        repeat (3) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
